// File: rtl/arb8_rr_ctrl_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// Protocol: req[i] is a level request held until gnt[i] is seen; gnt is one-hot or zero and
// stays set while req[i] stays high; dropping req[i] for one sampled edge releases the grant.
interface arb8_rr_ctrl_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;

  modport master (output req, input gnt, gnt_id, gnt_valid);
  modport slave  (input req, output gnt, gnt_id, gnt_valid);
endinterface

// File: rtl/arb8_rr_ctrl.sv
// Eight-way round-robin arbiter with registered one-hot grant and binary index.
// Optional hold timeout (forced rotation after MAX_HOLD cycles) under ARB_HOLD_TIMEOUT_EN.
module arb8_rr_ctrl #(
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  arb8_rr_ctrl_if.slave bus,
  output logic [0:0]    fsm_state
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state;
  logic [2:0] ptr;
  logic [2:0] own;
  logic [7:0] gnt_r;
  logic [2:0] gnt_id_r;

  logic [7:0] scan_req;
  logic       rotate;
  logic       keep;
  logic       win_found;
  logic [2:0] win_idx;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  logic [7:0] hcnt;
`endif

  always_comb begin
    rotate   = 1'b0;
    scan_req = bus.req;
`ifdef ARB_HOLD_TIMEOUT_EN
    // Owner hit its limit while someone else waits: hide it from this one scan.
    if (state == GRANT && bus.req[own] && hcnt == HOLD_MAX &&
        (bus.req & ~(8'd1 << own)) != 8'd0) begin
      rotate   = 1'b1;
      scan_req = bus.req & ~(8'd1 << own);
    end
`endif
    keep      = (state == GRANT) && bus.req[own] && !rotate;
    win_found = 1'b0;
    win_idx   = ptr;
    for (int i = 0; i < 8; i++) begin
      if (!win_found && scan_req[ptr + 3'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr + 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      own      <= 3'd0;
      gnt_r    <= 8'h00;
      gnt_id_r <= 3'd0;
`ifdef ARB_HOLD_TIMEOUT_EN
      hcnt     <= 8'd0;
`endif
    end else if (keep) begin
`ifdef ARB_HOLD_TIMEOUT_EN
      if (hcnt < HOLD_MAX) hcnt <= hcnt + 8'd1;
`endif
    end else if (win_found) begin
      // Covers first grant from IDLE, hand-off on release and forced rotation alike.
      state    <= GRANT;
      gnt_r    <= 8'd1 << win_idx;
      gnt_id_r <= win_idx;
      own      <= win_idx;
      ptr      <= win_idx + 3'd1;
`ifdef ARB_HOLD_TIMEOUT_EN
      hcnt     <= 8'd1;
`endif
    end else begin
      state <= IDLE;
      gnt_r <= 8'h00;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_id    = gnt_id_r;
  assign bus.gnt_valid = |gnt_r;
  assign fsm_state     = state;

endmodule

// File: tb/tb_arb8_rr_ctrl.sv
// Self-checking bench for arb8_rr_ctrl: directed scenarios plus a random run against a reference model.
module tb_arb8_rr_ctrl;
  localparam int MAX_HOLD = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:0] fsm_state;

  arb8_rr_ctrl_if bus();

  arb8_rr_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] exp_q[$];

  bit         m_busy;
  logic [2:0] m_own;
  logic [2:0] m_ptr;
  logic [2:0] m_gid;
  int         m_hcnt;

  task automatic model_reset();
    m_busy = 1'b0;
    m_own  = 3'd0;
    m_ptr  = 3'd0;
    m_gid  = 3'd0;
    m_hcnt = 0;
    exp_q.delete();
  endtask

  // Drives req (called away from the clock edge), advances the model, waits edge + 1.
  task automatic drive_cycle(input logic [7:0] r);
    logic [7:0] cand;
    logic [2:0] idx;
    bit         arb;
    cand = r;
    arb  = 1'b0;
    bus.req = r;
    if (!m_busy) arb = 1'b1;
    else if (!r[m_own]) arb = 1'b1;
    else if (TIMEOUT_ON && m_hcnt == MAX_HOLD && (r & ~(8'd1 << m_own)) != 8'd0) begin
      arb = 1'b1;
      cand[m_own] = 1'b0;
    end else if (m_hcnt < MAX_HOLD) m_hcnt++;
    if (arb) begin
      m_busy = 1'b0;
      for (int k = 0; k < 8; k++) begin
        idx = 3'((int'(m_ptr) + k) % 8);
        if (!m_busy && cand[idx]) begin
          m_busy = 1'b1;
          m_own  = idx;
          m_gid  = idx;
          m_hcnt = 1;
        end
      end
      if (m_busy) m_ptr = 3'((int'(m_own) + 1) % 8);
    end
    exp_q.push_back({m_busy ? (8'd1 << m_own) : 8'd0, m_gid, m_busy});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] e, got;
    bus.req = 8'h00;
    #1;
    n_cmp++;
    if ({bus.gnt, bus.gnt_id, bus.gnt_valid, fsm_state} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_initial got=%h exp=0", {bus.gnt, bus.gnt_id, bus.gnt_valid, fsm_state});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      drive_cycle(8'hFF);
      e = exp_q.pop_front();
      got = {bus.gnt, bus.gnt_id, bus.gnt_valid};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset_pregrant c=%0d got=%h exp=%h", c, got, e);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.gnt !== 8'h00 || bus.gnt_id !== 3'd0 || bus.gnt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async gnt=%h id=%0d valid=%b exp 00/0/0", bus.gnt, bus.gnt_id, bus.gnt_valid);
    end
    n_cmp++;
    if (fsm_state !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got=%b exp=0", fsm_state);
    end
    model_reset();
    #1 rst_n = 1'b1;
    drive_cycle(8'hFF);
    e = exp_q.pop_front();
    got = {bus.gnt, bus.gnt_id, bus.gnt_valid};
    n_cmp++;
    if (got !== e || bus.gnt !== 8'h01 || bus.gnt_id !== 3'd0) begin
      n_err++;
      $display("FAIL reset_first_grant got=%h exp=%h (gnt 01 id 0)", got, e);
    end
  endtask

  task automatic test_single();
    logic [11:0] e, got;
    logic [7:0]  seq [5] = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h00};
    for (int c = 0; c < 5; c++) begin
      drive_cycle(seq[c]);
      e = exp_q.pop_front();
      got = {bus.gnt, bus.gnt_id, bus.gnt_valid};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL single c=%0d got=%h exp=%h", c, got, e);
      end
      if (c == 1) begin
        n_cmp++;
        if (bus.gnt !== 8'h04 || bus.gnt_id !== 3'd2 || bus.gnt_valid !== 1'b1) begin
          n_err++;
          $display("FAIL single_grant gnt=%h id=%0d valid=%b exp 04/2/1", bus.gnt, bus.gnt_id, bus.gnt_valid);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.gnt_id !== 3'd2) begin
          n_err++;
          $display("FAIL single_release gnt=%h id=%0d valid=%b exp 00/2/0", bus.gnt, bus.gnt_id, bus.gnt_valid);
        end
      end
    end
  endtask

  task automatic test_rotation();
    logic [11:0] e, got;
    logic [7:0]  seq [7] = '{8'h81, 8'h81, 8'h80, 8'h81, 8'h01, 8'h81, 8'h80};
    logic [2:0]  ids [7] = '{3'd0, 3'd0, 3'd7, 3'd7, 3'd0, 3'd0, 3'd7};
    rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      drive_cycle(seq[c]);
      e = exp_q.pop_front();
      got = {bus.gnt, bus.gnt_id, bus.gnt_valid};
      n_cmp++;
      if (got !== e || bus.gnt_id !== ids[c] || bus.gnt_valid !== 1'b1) begin
        n_err++;
        $display("FAIL rotation c=%0d got=%h exp=%h id_exp=%0d", c, got, e, ids[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e, got;
    logic [7:0]  seq [4] = '{8'h00, 8'h08, 8'h08, 8'h22};
    for (int c = 0; c < 4; c++) begin
      drive_cycle(seq[c]);
      e = exp_q.pop_front();
      got = {bus.gnt, bus.gnt_id, bus.gnt_valid};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL b2b c=%0d got=%h exp=%h", c, got, e);
      end
    end
    n_cmp++;
    if (bus.gnt !== 8'h20 || bus.gnt_id !== 3'd5 || bus.gnt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_handoff gnt=%h id=%0d valid=%b exp 20/5/1", bus.gnt, bus.gnt_id, bus.gnt_valid);
    end
  endtask

  task automatic test_timeout();
    logic [11:0] e, got;
    logic [2:0]  id_exp;
    rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int n = 1; n <= 24; n++) begin
      drive_cycle(8'h03);
      e = exp_q.pop_front();
      got = {bus.gnt, bus.gnt_id, bus.gnt_valid};
      id_exp = 3'(((n - 1) / MAX_HOLD) % 2);
      n_cmp++;
      if (got !== e || bus.gnt_id !== id_exp) begin
        n_err++;
        $display("FAIL timeout_alt n=%0d got=%h exp=%h id_exp=%0d", n, got, e, id_exp);
      end
    end
    for (int n = 0; n < 10; n++) begin
      drive_cycle(8'h01);
      e = exp_q.pop_front();
      got = {bus.gnt, bus.gnt_id, bus.gnt_valid};
      n_cmp++;
      if (got !== e || bus.gnt_id !== 3'd0) begin
        n_err++;
        $display("FAIL timeout_solo n=%0d got=%h exp=%h", n, got, e);
      end
    end
`else
    id_exp = 3'd0;
    for (int n = 0; n < 100; n++) begin
      drive_cycle(8'h03);
      e = exp_q.pop_front();
      got = {bus.gnt, bus.gnt_id, bus.gnt_valid};
      n_cmp++;
      if (got !== e || bus.gnt_id !== id_exp || bus.gnt === 8'h02) begin
        n_err++;
        $display("FAIL no_timeout n=%0d got=%h exp=%h", n, got, e);
      end
    end
`endif
  endtask

  task automatic test_random();
    logic [11:0] e, got;
    logic [7:0]  r;
    r = 8'h00;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) r = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 2) == 0) r = r ^ (8'd1 << $urandom_range(0, 7));
      drive_cycle(r);
      e = exp_q.pop_front();
      got = {bus.gnt, bus.gnt_id, bus.gnt_valid};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL random n=%0d req=%h got=%h exp=%h", n, r, got, e);
      end
      n_cmp++;
      if (bus.gnt_valid !== (|bus.gnt) ||
          (bus.gnt_valid && bus.gnt !== (8'd1 << bus.gnt_id))) begin
        n_err++;
        $display("FAIL onehot n=%0d gnt=%h id=%0d valid=%b", n, bus.gnt, bus.gnt_id, bus.gnt_valid);
      end
    end
  endtask

  initial begin
    bus.req = 8'h00;
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
